// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Optional memory time-out watchdog is enabled by defining CTRL_MEM_TIMEOUT_EN.
module rv_multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ack,
    output logic             ir_we,
    output logic             dec_en,
    output logic             alu_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [6:0]       op_q;
    logic             trap_q;
    logic [1:0]       cause_q;
    logic [1:0]       cause_next;
    logic [CNT_W-1:0] instret_q;
    logic             legal;
    logic             retire;
    logic             timeout;

    // Opcode classes the datapath can execute
    always_comb begin
        legal = opcode inside {OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_LUI};
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;

    // Fires on the cycle that would be the TIMEOUT_CYCLES-th unacknowledged request cycle
    always_comb begin
        timeout = mem_req && !mem_ack && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    end

    // Wait counter: cleared on any state change, counts stalled request cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (mem_req && !mem_ack) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end
`else
    logic unused_timeout;

    // No watchdog: memory waits are unbounded
    always_comb begin
        timeout        = 1'b0;
        unused_timeout = (TIMEOUT_CYCLES == 0);
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and trap-cause selection
    always_comb begin
        state_next = state;
        cause_next = cause_q;
        case (state)
            S_FETCH: begin
                if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end else if (mem_ack) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_L, OP_S: state_next = S_MEM;
                    OP_B:       state_next = S_FETCH;
                    default:    state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end else if (mem_ack) begin
                    state_next = (op_q == OP_L) ? S_WB : S_FETCH;
                end
            end
            S_WB:    state_next = S_FETCH;
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    // Output decode; all strobes forced low while reset is asserted
    always_comb begin
        ir_we   = 1'b0;
        dec_en  = 1'b0;
        alu_en  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_sel = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 1'b0;
        rf_we   = 1'b0;
        wb_sel  = 2'b00;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                    pc_we   = mem_ack;
                end
                S_DECODE: begin
                    dec_en = 1'b1;
                end
                S_EXEC: begin
                    alu_en = 1'b1;
                    if (op_q == OP_B) begin
                        pc_we  = branch_taken;
                        pc_sel = 1'b1;
                    end else if (op_q == OP_JAL) begin
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_sel = 1'b1;
                    mem_we  = (op_q == OP_S);
                end
                S_WB: begin
                    rf_we = 1'b1;
                    case (op_q)
                        OP_L:    wb_sel = 2'b01;
                        OP_JAL:  wb_sel = 2'b10;
                        OP_LUI:  wb_sel = 2'b11;
                        default: wb_sel = 2'b00;
                    endcase
                end
                default: ;
            endcase
        end
        busy = !((state == S_FETCH) && !mem_req);
    end

    // Retire on any return to FETCH from the back half of the pipeline
    always_comb begin
        retire = (state_next == S_FETCH) &&
                 ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));
    end

    // Latched opcode, sticky trap and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q      <= 7'd0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
            if (state_next == S_TRAP) begin
                trap_q <= 1'b1;
            end
            cause_q <= cause_next;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: stimulus pushes hand-derived per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_rv_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ack;
    logic        ir_we, dec_en, alu_en, mem_req, mem_we, mem_sel;
    logic        pc_we, pc_sel, rf_we, busy, trap;
    logic [1:0]  wb_sel, trap_cause;
    logic [31:0] instret;

    rv_multicycle_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ack(mem_ack), .ir_we(ir_we), .dec_en(dec_en), .alu_en(alu_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .pc_we(pc_we),
        .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .busy(busy),
        .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    // Bit order: ir dec alu req we sel pcwe pcsel rf wb[1:0] busy trap cause[1:0]
    localparam logic [14:0] RST0   = 15'b0_0_0_0_0_0_0_0_0_00_0_0_00;
    localparam logic [14:0] F_WAIT = 15'b0_0_0_1_0_0_0_0_0_00_1_0_00;
    localparam logic [14:0] F_ACK  = 15'b1_0_0_1_0_0_1_0_0_00_1_0_00;
    localparam logic [14:0] DEC    = 15'b0_1_0_0_0_0_0_0_0_00_1_0_00;
    localparam logic [14:0] EX     = 15'b0_0_1_0_0_0_0_0_0_00_1_0_00;
    localparam logic [14:0] EX_BT  = 15'b0_0_1_0_0_0_1_1_0_00_1_0_00;
    localparam logic [14:0] EX_BN  = 15'b0_0_1_0_0_0_0_1_0_00_1_0_00;
    localparam logic [14:0] MEM_L  = 15'b0_0_0_1_0_1_0_0_0_00_1_0_00;
    localparam logic [14:0] MEM_S  = 15'b0_0_0_1_1_1_0_0_0_00_1_0_00;
    localparam logic [14:0] WB00   = 15'b0_0_0_0_0_0_0_0_1_00_1_0_00;
    localparam logic [14:0] WB01   = 15'b0_0_0_0_0_0_0_0_1_01_1_0_00;
    localparam logic [14:0] WB10   = 15'b0_0_0_0_0_0_0_0_1_10_1_0_00;
    localparam logic [14:0] WB11   = 15'b0_0_0_0_0_0_0_0_1_11_1_0_00;
    localparam logic [14:0] TRP01  = 15'b0_0_0_0_0_0_0_0_0_00_1_1_01;
    localparam logic [14:0] TRP10  = 15'b0_0_0_0_0_0_0_0_0_00_1_1_10;
    localparam logic [14:0] M_ALL  = 15'h7FFF;
    localparam logic [14:0] M_STB  = 15'b1_1_1_1_1_1_1_1_1_11_0_0_00;

    typedef struct {
        logic [14:0] sig;
        logic [14:0] mask;
        logic [31:0] ei;
        logic        ci;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue what the outputs must be in that cycle
    task automatic step(input logic r, input logic [6:0] op, input logic bt, input logic ack,
                        input logic [14:0] e, input logic [14:0] m, input logic [31:0] ei,
                        input logic ci, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst          = r;
        opcode       = op;
        branch_taken = bt;
        mem_ack      = ack;
        x.sig  = e;
        x.mask = m;
        x.ei   = ei;
        x.ci   = ci;
        x.nm   = nm;
        q.push_back(x);
    endtask

    task automatic s(input logic [6:0] op, input logic bt, input logic ack,
                     input logic [14:0] e, input logic [31:0] ei, input string nm);
        step(1'b1, op, bt, ack, e, M_ALL, ei, 1'b1, nm);
    endtask

    // Monitor: compare the DUT against the oldest pending expectation
    always @(negedge clk) begin
        exp_t        x;
        logic [14:0] got;
        if (q.size() != 0) begin
            x   = q.pop_front();
            got = {ir_we, dec_en, alu_en, mem_req, mem_we, mem_sel, pc_we, pc_sel,
                   rf_we, wb_sel, busy, trap, trap_cause};
            n_chk++;
            if (((got ^ x.sig) & x.mask) == 15'd0) n_pass++;
            else $display("FAIL %s outputs got %h want %h (mask %h)", x.nm, got, x.sig, x.mask);
            if (x.ci) begin
                n_chk++;
                if (instret === x.ei) n_pass++;
                else $display("FAIL %s instret got %0d want %0d", x.nm, instret, x.ei);
            end
        end
    end

    initial begin
        rst          = 1'b0;
        opcode       = 7'h00;
        branch_taken = 1'b0;
        mem_ack      = 1'b0;

        // reset state: idle FETCH slot, no strobes, no trap
        step(1'b0, 7'h00, 1'b0, 1'b0, RST0, M_ALL, 32'd0, 1'b1, "reset");

        // ADD, zero-wait
        s(7'h33, 0, 1, F_ACK, 0, "add_fetch");
        s(7'h33, 0, 1, DEC,   0, "add_dec");
        s(7'h33, 0, 1, EX,    0, "add_exec");
        s(7'h33, 0, 1, WB00,  0, "add_wb");

        // LW with two wait cycles per ack; opcode input scrambled after DECODE
        s(7'h03, 0, 0, F_WAIT, 1, "lw_fetch_w0");
        s(7'h03, 0, 0, F_WAIT, 1, "lw_fetch_w1");
        s(7'h03, 0, 1, F_ACK,  1, "lw_fetch_ack");
        s(7'h03, 0, 1, DEC,    1, "lw_dec");
        s(7'h7F, 0, 0, EX,     1, "lw_exec");
        s(7'h7F, 0, 0, MEM_L,  1, "lw_mem_w0");
        s(7'h7F, 0, 0, MEM_L,  1, "lw_mem_w1");
        s(7'h7F, 0, 1, MEM_L,  1, "lw_mem_ack");
        s(7'h7F, 0, 1, WB01,   1, "lw_wb");

        // BEQ taken / not taken
        s(7'h63, 0, 1, F_ACK, 2, "beq_t_fetch");
        s(7'h63, 1, 1, DEC,   2, "beq_t_dec");
        s(7'h63, 1, 1, EX_BT, 2, "beq_t_exec");
        s(7'h63, 0, 1, F_ACK, 3, "beq_n_fetch");
        s(7'h63, 1, 1, DEC,   3, "beq_n_dec");
        s(7'h63, 0, 1, EX_BN, 3, "beq_n_exec");

        // JAL
        s(7'h6F, 0, 1, F_ACK, 4, "jal_fetch");
        s(7'h6F, 0, 1, DEC,   4, "jal_dec");
        s(7'h6F, 0, 1, EX_BT, 4, "jal_exec");
        s(7'h6F, 0, 1, WB10,  4, "jal_wb");

        // LUI
        s(7'h37, 0, 1, F_ACK, 5, "lui_fetch");
        s(7'h37, 0, 1, DEC,   5, "lui_dec");
        s(7'h37, 0, 1, EX,    5, "lui_exec");
        s(7'h37, 0, 1, WB11,  5, "lui_wb");

        // SW zero-wait
        s(7'h23, 0, 1, F_ACK, 6, "sw_fetch");
        s(7'h23, 0, 1, DEC,   6, "sw_dec");
        s(7'h23, 0, 1, EX,    6, "sw_exec");
        s(7'h23, 0, 1, MEM_S, 6, "sw_mem");

        // I-type
        s(7'h13, 0, 1, F_ACK, 7, "addi_fetch");
        s(7'h13, 0, 1, DEC,   7, "addi_dec");
        s(7'h13, 0, 1, EX,    7, "addi_exec");
        s(7'h13, 0, 1, WB00,  7, "addi_wb");

        // Illegal opcode: terminal TRAP, ack ignored
        s(7'h7F, 0, 1, F_ACK, 8, "ill_fetch");
        s(7'h7F, 0, 1, DEC,   8, "ill_dec");
        s(7'h7F, 0, 1, TRP01, 8, "ill_trap0");
        s(7'h7F, 0, 1, TRP01, 8, "ill_trap1");
        s(7'h7F, 0, 1, TRP01, 8, "ill_trap2");
        step(1'b0, 7'h7F, 1'b0, 1'b0, RST0, M_STB, 32'd0, 1'b0, "trap_rst");
        s(7'h23, 0, 0, F_WAIT, 0, "post_trap_fetch");

        // SW interrupted by reset in MEM; ack during reset is ignored
        s(7'h23, 0, 1, F_ACK, 0, "swr_fetch");
        s(7'h23, 0, 1, DEC,   0, "swr_dec");
        s(7'h23, 0, 1, EX,    0, "swr_exec");
        s(7'h23, 0, 0, MEM_S, 0, "swr_mem_wait");
        step(1'b0, 7'h23, 1'b0, 1'b1, RST0, M_STB, 32'd0, 1'b0, "swr_rst");
        s(7'h13, 0, 1, F_ACK, 0, "swr_refetch");
        s(7'h13, 0, 1, DEC,   0, "swr_dec2");
        s(7'h13, 0, 1, EX,    0, "swr_exec2");
        s(7'h13, 0, 1, WB00,  0, "swr_wb2");

`ifdef CTRL_MEM_TIMEOUT_EN
        // Starved fetch: 16 waiting cycles then time-out trap
        for (int i = 0; i < 16; i++) s(7'h13, 0, 0, F_WAIT, 1, "to_wait");
        s(7'h13, 0, 1, TRP10, 1, "to_trap0");
        s(7'h13, 0, 1, TRP10, 1, "to_trap1");
`else
        // Starved fetch: request held indefinitely
        for (int i = 0; i < 100; i++) s(7'h13, 0, 0, F_WAIT, 1, "hold_wait");
        s(7'h13, 0, 0, F_WAIT, 1, "hold_still_req");
`endif

        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain pending got %0d want 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It steps every instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the enable strobes for the instruction register, the ALU-control decoder and ALU, the data-memory port, the PC and the register file. It sits between the shared memory port (req/ack handshake) and the datapath, and reports illegal opcodes and memory time-outs as a sticky trap.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles to wait for mem_ack. Used only with CTRL_MEM_TIMEOUT_EN.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk, input, 1: core clock. All state changes on the rising edge.
- rst, input, 1: reset, synchronous, active-low.
- opcode, input, 7: instr[6:0] from the instruction register. Valid from DECODE onward.
- branch_taken, input, 1: branch-compare result from the ALU. Sampled in EXEC.
- mem_ack, input, 1: memory completion. Meaningful only while mem_req=1.
- ir_we, output, 1: load the instruction register with the fetched word.
- dec_en, output, 1: latch the ALU-control decode and immediate.
- alu_en, output, 1: ALU result register enable.
- mem_req, output, 1: memory request. Held until ack.
- mem_we, output, 1: request is a store. Valid with mem_req.
- mem_sel, output, 1: 0 = instruction fetch address (PC), 1 = data address (ALU result).
- pc_we, output, 1: PC update strobe.
- pc_sel, output, 1: 0 = PC+4, 1 = branch/jump target.
- rf_we, output, 1: register-file write strobe.
- wb_sel, output, 2: 00 ALU, 01 load data, 10 PC+4, 11 immediate.
- busy, output, 1: 0 only while in FETCH with mem_req not yet issued (idle slot). Otherwise 1.
- trap, output, 1: sticky error flag.
- trap_cause, output, 2: 01 illegal opcode, 10 memory time-out, 00 none.
- instret, output, CNT_W: instructions retired.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. State is held in a registered state variable.
- Outputs are a Moore decode of the state, except for these ack-qualified strobes:
  - ir_we = FETCH & mem_ack.
  - pc_we(PC+4) = FETCH & mem_ack.
- FETCH:
  - Drives mem_req=1, mem_sel=0, mem_we=0.
  - On mem_ack, asserts ir_we=1, pc_we=1, pc_sel=0, then goes to DECODE.
  - Without ack, stays in FETCH.
- DECODE:
  - Drives dec_en=1.
  - Opcodes 0110011 (R), 0010011 (I), 0000011 (L), 0100011 (S), 1100011 (B), 1101111 (JAL) and 0110111 (LUI) go to EXEC.
  - Any other opcode goes to TRAP with trap_cause=01.
- EXEC:
  - Drives alu_en=1.
  - R, I and LUI go to WB.
  - L and S go to MEM.
  - B: pc_we=branch_taken, pc_sel=1, then FETCH (retire).
  - JAL: pc_we=1, pc_sel=1, then WB.
- MEM:
  - Drives mem_req=1, mem_sel=1, mem_we=(S).
  - On ack, L goes to WB and S goes to FETCH (retire).
- WB:
  - Drives rf_we=1.
  - wb_sel: R/I = 00, L = 01, JAL = 10, LUI = 11.
  - Then goes to FETCH (retire).
- Retire: instret increments by 1 on each transition into FETCH from EXEC, MEM or WB. It wraps modulo 2^CNT_W.
- TRAP:
  - All strobes are 0; busy=1, trap=1.
  - It is terminal; only rst exits it.
- Writes to x0 are not suppressed here (rf_we still pulses); the register file discards them.
- mem_ack while mem_req=0 is ignored.
- Opcode is latched into an internal register in DECODE. Later changes on the opcode input do not affect EXEC/MEM/WB.

## Timing
- Reset (rst=0 at an edge):
  - state=FETCH, trap=0, trap_cause=00, instret=0.
  - Every output strobe is 0 during reset.
  - The first cycle after reset has mem_req=1.
- Reset mid-operation, including MEM with an outstanding request: the controller returns to FETCH on the next edge. A late ack is ignored unless it arrives while the new fetch mem_req is high.
- Zero-wait memory (ack in the same cycle as req), cycles per instruction:
  - B: 3.
  - R, I, LUI, JAL, S: 4.
  - L: 5.
- Each wait cycle on mem_ack adds 1.
- The handshake completes on the edge where mem_req=1 and mem_ack=1. mem_req falls in the following cycle unless the next state issues a new request.
- branch_taken is sampled only on the EXEC edge.

## Configuration
- CTRL_MEM_TIMEOUT_EN:
  - Defined: a wait counter resets on entry to FETCH or MEM and counts each cycle with mem_req=1 and mem_ack=0. When it reaches TIMEOUT_CYCLES, the next state is TRAP with trap_cause=10.
  - Undefined: no counter; FETCH/MEM wait indefinitely and trap_cause=10 never occurs.

## Test plan
- Reset, then ADD (0x002081B3) with ack tied 1 -> ir_we at cycle 0, dec_en at 1, alu_en at 2, rf_we with wb_sel=00 at 3, mem_req at 4, instret=1.
- LW (opcode 0000011) with 2 wait cycles on each ack -> MEM has mem_sel=1, mem_we=0; rf_we with wb_sel=01; total 9 cycles; instret +1.
- BEQ: branch_taken=1 -> pc_we=1, pc_sel=1 in EXEC. Same test with branch_taken=0 -> pc_we=0. Both cases retire in 3 cycles and issue no rf_we.
- Opcode 0x7F -> TRAP after DECODE, trap=1, trap_cause=01, no further mem_req. Then rst=0 for 1 cycle -> state FETCH, trap=0, instret=0.
- With CTRL_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold mem_ack=0 -> trap_cause=10 after 16 cycles. Without the macro, mem_req is still 1 after 100 cycles.
- SW in MEM with rst asserted before ack -> FETCH next cycle with mem_we=0; the stale ack is not counted; instret unchanged.
